// File: rtl/seq_binbcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package binbcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // Decimal digits needed for a WIDTH-bit unsigned value (log10(2) ~ 0.301).
  function automatic int unsigned digits_for(input int unsigned width);
    return (width * 301) / 1000 + 1;
  endfunction

endpackage

// File: rtl/seq_binbcd_if.sv
// Input/output valid-ready handshake bundle for seq_binbcd.
interface seq_binbcd_if
  import binbcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = digits_for(WIDTH)
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_neg;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bcd, out_neg
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bcd, out_neg
  );

endinterface

// File: rtl/seq_binbcd_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more.
module bcd_add3_cell
  import binbcd_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/seq_binbcd.sv
// Multi-cycle shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// optional signed-magnitude input, valid/ready on both sides.
module seq_binbcd
  import binbcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter bit          SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  seq_binbcd_if.slave   bus
);

  localparam int unsigned DIGITS = digits_for(WIDTH);
  localparam int unsigned CW     = $clog2(WIDTH + 1);

  state_t                r_state, w_state_nxt;
  logic [WIDTH-1:0]      r_bin, w_bin_nxt;
  logic [4*DIGITS-1:0]   r_bcd, w_bcd_nxt, w_bcd_adj;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_neg, w_neg_nxt;
  logic                  w_in_neg;
  logic [WIDTH-1:0]      w_mag;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the
  // correct magnitude when read back as unsigned.
  assign w_in_neg = SIGNED & bus.in_data[WIDTH-1];
  assign w_mag    = w_in_neg ? ('0 - bus.in_data) : bus.in_data;

  for (genvar k = 0; k < DIGITS; k++) begin : g_cell
    bcd_add3_cell u_cell (
      .i_digit (r_bcd[4*k +: 4]),
      .o_digit (w_bcd_adj[4*k +: 4])
    );
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bin_nxt     = r_bin;
    w_bcd_nxt     = r_bcd;
    w_cnt_nxt     = r_cnt;
    w_neg_nxt     = r_neg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = SHIFT;
          w_bin_nxt   = w_mag;
          w_bcd_nxt   = '0;
          w_neg_nxt   = w_in_neg;
          w_cnt_nxt   = CW'(WIDTH);
        end
      end
      SHIFT: begin
        {w_bcd_nxt, w_bin_nxt} = {w_bcd_adj, r_bin} << 1;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_bcd   <= w_bcd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_neg   <= w_neg_nxt;
    end
  end

  assign bus.out_bcd = r_bcd;
  assign bus.out_neg = r_neg;

endmodule
